// File: rtl/aha_clk_div_sel_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aha_clk_ctrl_pkg
// Shared types and constants for the divided-clock ratio select controller.
//   state_t     : controller FSM states
//   SEL_DIV*    : mux select codes for /1 .. /32
//   SEL_W       : width of a ratio select
//   NUM_RATIOS  : number of divider taps (one enable strobe per tap)
// ---------------------------------------------------------------------------
package aha_clk_ctrl_pkg;

  localparam int SEL_W      = 3;
  localparam int NUM_RATIOS = 6;

  localparam logic [SEL_W-1:0] SEL_DIV1  = 3'd0;
  localparam logic [SEL_W-1:0] SEL_DIV2  = 3'd1;
  localparam logic [SEL_W-1:0] SEL_DIV4  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_DIV8  = 3'd3;
  localparam logic [SEL_W-1:0] SEL_DIV16 = 3'd4;
  localparam logic [SEL_W-1:0] SEL_DIV32 = 3'd5;
  localparam logic [SEL_W-1:0] SEL_MAX   = SEL_DIV32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OFF = 2'd1,
    DRAIN    = 2'd2,
    WAIT_ON  = 2'd3
  } state_t;

endpackage

// File: rtl/aha_clk_div_sel_ctrl_if.sv
// ---------------------------------------------------------------------------
// aha_clk_div_sel_ctrl_if
// Request handshake, divider strobes and clock-control outputs of the
// ratio select controller.
//   master : register block / divider side (drives request and strobes)
//   slave  : the controller
// ---------------------------------------------------------------------------
interface aha_clk_div_sel_ctrl_if;

  logic [aha_clk_ctrl_pkg::NUM_RATIOS-1:0] div_en;
  logic                                    req_valid;
  logic [aha_clk_ctrl_pkg::SEL_W-1:0]      req_sel;
  logic                                    req_ready;
  logic [aha_clk_ctrl_pkg::SEL_W-1:0]      mux_sel;
  logic                                    gate_en;
  logic                                    busy;
  logic                                    ack;
  logic                                    err;

  modport master (
    output div_en, req_valid, req_sel,
    input  req_ready, mux_sel, gate_en, busy, ack, err
  );

  modport slave (
    input  div_en, req_valid, req_sel,
    output req_ready, mux_sel, gate_en, busy, ack, err
  );

endinterface

// File: rtl/aha_clk_div_sel_ctrl_strobe_pick.sv
// ---------------------------------------------------------------------------
// aha_strobe_pick
// Combinational 6:1 pick of one divider enable strobe.
//   div_en : one strobe per divider tap
//   idx    : tap index (0..5)
//   strobe : div_en[idx], or 0 for an index beyond the last tap
// ---------------------------------------------------------------------------
module aha_strobe_pick
  import aha_clk_ctrl_pkg::*;
(
  input  logic [NUM_RATIOS-1:0] div_en,
  input  logic [SEL_W-1:0]      idx,
  output logic                  strobe
);

  always_comb begin
    strobe = 1'b0;
    case (idx)
      3'd0:    strobe = div_en[0];
      3'd1:    strobe = div_en[1];
      3'd2:    strobe = div_en[2];
      3'd3:    strobe = div_en[3];
      3'd4:    strobe = div_en[4];
      3'd5:    strobe = div_en[5];
      default: strobe = 1'b0;
    endcase
  end

endmodule

// File: rtl/aha_clk_div_sel_ctrl.sv
// ---------------------------------------------------------------------------
// aha_clk_div_sel_ctrl
// Sequences glitch-free run-time changes of the divided-clock ratio: gates
// the downstream clock on a boundary of the current ratio, drains, switches
// the mux select, then re-opens the gate on a boundary of the new ratio.
//   clk_in : reference (undivided) clock, same as the divider's
//   reset  : asynchronous, active-high
//   bus    : request handshake, divider strobes, mux select, gate enable,
//            busy and the one-cycle ack / err completion pulses
// ---------------------------------------------------------------------------
module aha_clk_div_sel_ctrl
  import aha_clk_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int WAIT_MAX     = 63,
  parameter int RESET_SEL    = 0
) (
  input  logic                   clk_in,
  input  logic                   reset,
  aha_clk_div_sel_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (WAIT_MAX > DRAIN_CYCLES) ? WAIT_MAX : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [SEL_W-1:0] RESET_MUX  = SEL_W'(RESET_SEL);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SEL_W-1:0] target, target_nx;
  logic [SEL_W-1:0] mux_q, mux_nx;
  logic             gate_q, gate_nx;
  logic             ack_q, ack_nx;
  logic             err_q, err_nx;
  logic             busy_q;
  logic             strobe;

  // The strobe always follows the live select, so WAIT_ON automatically
  // watches the new ratio once DRAIN has switched the mux.
  aha_strobe_pick u_pick (
    .div_en (bus.div_en),
    .idx    (mux_q),
    .strobe (strobe)
  );

  // All controller state and outputs are registered together so no input
  // reaches an output combinationally; busy/ready are precomputed from the
  // next state.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= RESET_MUX;
      mux_q  <= RESET_MUX;
      gate_q <= 1'b1;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      target <= target_nx;
      mux_q  <= mux_nx;
      gate_q <= gate_nx;
      ack_q  <= ack_nx;
      err_q  <= err_nx;
      busy_q <= (state_nx != IDLE);
    end
  end

  // Next-state logic. One counter serves both the strobe-wait timeout
  // (counting up) and the drain interval (counting down). A request is only
  // looked at in IDLE, which is exactly when ready is high.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    target_nx = target;
    mux_nx    = mux_q;
    gate_nx   = gate_q;
    ack_nx    = 1'b0;
    err_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_sel > SEL_MAX) begin
            err_nx = 1'b1;
          end else if (bus.req_sel == mux_q) begin
            ack_nx = 1'b1;
          end else begin
            target_nx = bus.req_sel;
            cnt_nx    = '0;
            state_nx  = WAIT_OFF;
          end
        end
      end
      WAIT_OFF: begin
        if (strobe) begin
          gate_nx  = 1'b0;
          cnt_nx   = DRAIN_LOAD;
          state_nx = DRAIN;
        end else if (cnt == WAIT_LAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          mux_nx   = target;
          cnt_nx   = '0;
          state_nx = WAIT_ON;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      WAIT_ON: begin
        // On timeout the gate is forced open so the downstream domain is
        // never left stopped; the new select is kept.
        if (strobe) begin
          gate_nx  = 1'b1;
          ack_nx   = 1'b1;
          state_nx = IDLE;
        end else if (cnt == WAIT_LAST) begin
          gate_nx  = 1'b1;
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.mux_sel   = mux_q;
  assign bus.gate_en   = gate_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.req_ready = ~busy_q;

endmodule

// File: tb/tb_aha_clk_div_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aha_clk_div_sel_ctrl
// Self-checking bench for aha_clk_div_sel_ctrl. A request-level model
// predicts, from the strobe pattern the bench itself generates, the edge on
// which the gate closes, the mux switches and the request completes; every
// edge is compared against that timeline.
// ---------------------------------------------------------------------------
module tb_aha_clk_div_sel_ctrl;

  localparam int DRAIN_CYCLES = 4;
  localparam int WAIT_MAX     = 63;
  localparam int RESET_SEL    = 0;
  localparam int INF          = 1 << 30;
  localparam logic [7:0] RST_VEC = {3'(RESET_SEL), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic clk;
  logic reset;
  int   total;
  int   bad;

  aha_clk_div_sel_ctrl_if bus ();

  aha_clk_div_sel_ctrl #(
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .WAIT_MAX     (WAIT_MAX),
    .RESET_SEL    (RESET_SEL)
  ) dut (
    .clk_in (clk),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe generator settings and the model's view of the world
  int edge_n;
  int phase;
  bit en_on;
  int en_cut;
  int cur_sel;
  int p_a, p_end, p_goff, p_m, p_old, p_new;
  bit p_ok;

  // Divider strobes as seen on edge e: bit k pulses once every 2^k edges
  function automatic logic [5:0] strobes(int e);
    logic [5:0] s;
    s = '0;
    for (int k = 0; k < 6; k++)
      s[k] = en_on && (e < en_cut) && (((e + phase) % (1 << k)) == 0);
    return s;
  endfunction

  // Expected {mux, gate, ready, busy, ack, err} after edge e
  function automatic logic [7:0] exp_vec(int e);
    logic [2:0] m;
    logic       g, b, a, r;
    m = (e >= p_m) ? 3'(p_new) : 3'(p_old);
    g = !(e >= p_goff && e < p_end);
    b = (e >= p_a && e < p_end);
    a = (e == p_end) && p_ok;
    r = (e == p_end) && !p_ok;
    return {m, g, !b, b, a, r};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {bus.mux_sel, bus.gate_en, bus.req_ready, bus.busy, bus.ack, bus.err};
  endfunction

  task automatic tick();
    bus.div_en = strobes(edge_n + 1);
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Predict the outcome of a request accepted on the next edge, from the
  // rules: close on the first old-ratio strobe, drain, switch, open on the
  // first new-ratio strobe, each wait bounded by WAIT_MAX+1 samples.
  task automatic predict(input int sel);
    int e;
    p_a = edge_n + 1;
    p_old = cur_sel;
    p_new = sel;
    p_goff = INF;
    p_m = INF;
    if (sel > 5) begin
      p_end = p_a; p_ok = 0;
    end else if (sel == cur_sel) begin
      p_end = p_a; p_ok = 1;
    end else begin
      p_end = p_a + WAIT_MAX + 1;
      p_ok = 0;
      for (e = p_a + 1; e <= p_a + WAIT_MAX + 1; e++)
        if (strobes(e)[cur_sel]) begin p_goff = e; break; end
      if (p_goff != INF) begin
        p_m = p_goff + DRAIN_CYCLES;
        p_end = p_m + WAIT_MAX + 1;
        for (e = p_m + 1; e <= p_m + WAIT_MAX + 1; e++)
          if (strobes(e)[sel]) begin p_end = e; p_ok = 1; break; end
      end
    end
  endtask

  // Present a request for exactly the accept edge and advance through it
  task automatic issue(input int sel);
    predict(sel);
    bus.req_valid = 1'b1;
    bus.req_sel = 3'(sel);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    reset = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_sel = 3'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = obs_vec();
      total++;
      if (got !== RST_VEC) begin
        bad++;
        $display("[TB] FAIL reset_hold cyc%0d got=%b exp=%b", i, got, RST_VEC);
      end
    end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    tick();
    got = obs_vec();
    total++;
    if (got !== RST_VEC) begin
      bad++;
      $display("[TB] FAIL reset_release got=%b exp=%b", got, RST_VEC);
    end
    cur_sel = RESET_SEL;
  endtask

  task automatic test_illegal();
    logic [7:0] got, exp;
    for (int s = 6; s <= 7; s++) begin
      issue(s);
      for (int e = p_a; e <= p_end + 2; e++) begin
        if (e > p_a) tick();
        got = obs_vec(); exp = exp_vec(e);
        total++;
        if (got !== exp) begin
          bad++;
          $display("[TB] FAIL illegal sel=%0d edge+%0d got=%b exp=%b", s, e - p_a, got, exp);
        end
      end
    end
  endtask

  task automatic test_same();
    logic [7:0] got, exp;
    issue(cur_sel);
    for (int e = p_a; e <= p_end + 2; e++) begin
      if (e > p_a) tick();
      got = obs_vec(); exp = exp_vec(e);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL same_sel edge+%0d got=%b exp=%b", e - p_a, got, exp);
      end
    end
  endtask

  task automatic test_switch();
    logic [7:0] got, exp;
    en_on = 1; en_cut = INF; phase = $urandom_range(0, 31);
    issue(3);
    for (int e = p_a; e <= p_end + 2; e++) begin
      if (e > p_a) begin
        bus.req_valid = (e <= p_end);
        bus.req_sel = 3'($urandom_range(0, 7));
        tick();
      end
      got = obs_vec(); exp = exp_vec(e);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL switch_0_3 edge+%0d got=%b exp=%b", e - p_a, got, exp);
      end
    end
    bus.req_valid = 1'b0;
    if (p_m != INF) cur_sel = p_new;
  endtask

  task automatic test_timeout();
    logic [7:0] got, exp;
    en_on = 0;
    issue(2);
    for (int e = p_a; e <= p_end + 2; e++) begin
      if (e > p_a) tick();
      got = obs_vec(); exp = exp_vec(e);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL timeout edge+%0d got=%b exp=%b", e - p_a, got, exp);
      end
    end
    if (p_m != INF) cur_sel = p_new;
    en_on = 1;
  endtask

  task automatic test_mid_reset();
    logic [7:0] got, exp;
    int sel;
    en_on = 1; en_cut = INF; phase = $urandom_range(0, 31);
    sel = (cur_sel + 1 + $urandom_range(0, 4)) % 6;
    issue(sel);
    for (int e = p_a; e <= p_goff + 1; e++) begin
      if (e > p_a) tick();
      got = obs_vec(); exp = exp_vec(e);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL mid_reset_pre edge+%0d got=%b exp=%b", e - p_a, got, exp);
      end
    end
    #2 reset = 1'b1;
    #1;
    got = obs_vec();
    total++;
    if (got !== RST_VEC) begin
      bad++;
      $display("[TB] FAIL mid_reset_async got=%b exp=%b", got, RST_VEC);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) reset = 1'b0;
      tick();
      got = obs_vec();
      total++;
      if (got !== RST_VEC) begin
        bad++;
        $display("[TB] FAIL mid_reset_after cyc%0d got=%b exp=%b", i, got, RST_VEC);
      end
    end
    cur_sel = RESET_SEL;
    sel = 1 + $urandom_range(0, 4);
    issue(sel);
    for (int e = p_a; e <= p_end + 2; e++) begin
      if (e > p_a) tick();
      got = obs_vec(); exp = exp_vec(e);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL mid_reset_next edge+%0d got=%b exp=%b", e - p_a, got, exp);
      end
    end
    if (p_m != INF) cur_sel = p_new;
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    int sel, mode;
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 7);
      mode = $urandom_range(0, 3);
      phase = $urandom_range(0, 31);
      en_on = (mode != 2);
      en_cut = (mode == 3) ? (edge_n + 1 + (1 << cur_sel) + 1) : INF;
      issue(sel);
      for (int e = p_a; e <= p_end + 2; e++) begin
        if (e > p_a) begin
          bus.req_valid = (e <= p_end) && ($urandom_range(0, 1) == 1);
          bus.req_sel = 3'($urandom_range(0, 7));
          tick();
        end
        got = obs_vec(); exp = exp_vec(e);
        total++;
        if (got !== exp) begin
          bad++;
          $display("[TB] FAIL random n=%0d sel=%0d mode=%0d edge+%0d got=%b exp=%b",
                   n, sel, mode, e - p_a, got, exp);
        end
      end
      bus.req_valid = 1'b0;
      if (p_m != INF) cur_sel = p_new;
    end
    en_on = 1; en_cut = INF;
  endtask

  initial begin
    total = 0;
    bad = 0;
    edge_n = 0;
    phase = 0;
    en_on = 1;
    en_cut = INF;
    cur_sel = RESET_SEL;
    reset = 1'b1;
    bus.div_en = '0;
    bus.req_valid = 1'b0;
    bus.req_sel = '0;
    test_reset();
    test_illegal();
    test_same();
    test_switch();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
